// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared FSM encoding and width defaults for pipeline_divider.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int PIPE_W     = 10;
    localparam int PIPE_CNT_W = $clog2(PIPE_W);

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division step (shift, trial subtract).
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int W = 10
) (
    input  logic [W-1:0] i_rem,
    input  logic         i_dividend_bit,
    input  logic [W-1:0] i_divisor,
    output logic [W-1:0] o_rem,
    output logic         o_quot_bit
);

    logic [W:0] w_shifted;
    logic [W:0] w_diff;

    // Partial remainder is always below the divisor, so W+1 bits hold the sign.
    assign w_shifted  = {i_rem, i_dividend_bit};
    assign w_diff     = w_shifted - {1'b0, i_divisor};
    assign o_quot_bit = ~w_diff[W];
    assign o_rem      = o_quot_bit ? w_diff[W-1:0] : w_shifted[W-1:0];

endmodule
`default_nettype wire

// File: rtl/pipeline_divider.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_divider
// Description : Sequential restoring divider, one quotient bit per cycle.
//               Define PIPE_DIV_REM_EN to expose the remainder port.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_divider
    import pipe_pkg::*;
#(
    parameter int W = PIPE_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] quot,
`ifdef PIPE_DIV_REM_EN
    output logic [W-1:0] rem,
`endif
    output logic         div_zero
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_rem;
    logic [W-1:0]     r_quot;
    logic [W-1:0]     r_divisor;
    logic             r_div_zero;
    logic [W-1:0]     w_rem_next;
    logic             w_quot_bit;
    logic [W:0]       w_quot_shift;

    div_step #(.W(W)) u_div_step (
        .i_rem          (r_rem),
        .i_dividend_bit (r_quot[W-1]),
        .i_divisor      (r_divisor),
        .o_rem          (w_rem_next),
        .o_quot_bit     (w_quot_bit)
    );

    // r_quot starts as the dividend; its MSBs feed the step while quotient bits fill from the LSB.
    assign w_quot_shift = {r_quot, w_quot_bit};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)       w_state_next = RUN;
            RUN:     if (r_cnt == '0)    w_state_next = DONE;
            DONE:    if (out_ready)      w_state_next = IDLE;
            default:                     w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
            r_divisor  <= '0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_quot     <= dividend;
                        r_divisor  <= divisor;
                        r_rem      <= '0;
                        r_cnt      <= CNT_W'(W - 1);
                        r_div_zero <= (divisor == '0);
                    end
                end
                RUN: begin
                    r_rem  <= w_rem_next;
                    r_quot <= w_quot_shift[W-1:0];
                    r_cnt  <= r_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign quot      = r_quot;
    assign div_zero  = r_div_zero;
`ifdef PIPE_DIV_REM_EN
    assign rem       = r_rem;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_divider
// Description : Scoreboard bench for pipeline_divider.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_divider;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quot;
    logic         div_zero;
`ifdef PIPE_DIV_REM_EN
    logic [W-1:0] rem;
`endif

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipeline_divider #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot      (quot),
`ifdef PIPE_DIV_REM_EN
        .rem       (rem),
`endif
        .div_zero  (div_zero)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
        end
        sb.push_back(e);
    endtask

    // Leaves in_valid high; returns #1 after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        tick();
        push_exp(a, b);
    endtask

    // lat0 is the cycle index (accept cycle = 0) at the moment of the call.
    task automatic collect(input string tag, input int stall, input int lat0);
        exp_t e;
        int   lat;
        lat = lat0;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, W + 1);
        if (!out_valid) return;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_quot"}, quot, e.q);
        chk({tag, "_dz"}, div_zero, e.dz);
`ifdef PIPE_DIV_REM_EN
        chk({tag, "_rem"}, rem, e.r);
`endif
        out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            tick();
            chk({tag, "_stall_valid"}, out_valid, 1'b1);
            chk({tag, "_stall_quot"}, quot, e.q);
`ifdef PIPE_DIV_REM_EN
            chk({tag, "_stall_rem"}, rem, e.r);
`endif
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_post_in_ready"}, in_ready, 1'b1);
        chk({tag, "_post_out_valid"}, out_valid, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        tick();
        tick();
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_quot", quot, 0);
        chk("rst_dz", div_zero, 1'b0);
`ifdef PIPE_DIV_REM_EN
        chk("rst_rem", rem, 0);
`endif
        rst = 1'b0;
        tick();

        send(300, 20);  in_valid = 1'b0; collect("d300_20", 0, 1);
        send(1023, 7);  in_valid = 1'b0; collect("d1023_7", 0, 1);
        send(1, 1023);  in_valid = 1'b0; collect("d1_1023", 0, 1);
        send(5, 0);     in_valid = 1'b0; collect("d5_0", 0, 1);
        send(300, 20);  in_valid = 1'b0; collect("stall", 5, 1);

        // New operands held on in_valid while busy must be ignored.
        send(50, 7);
        dividend = 100;
        divisor  = 3;
        tick();
        chk("hold_in_ready", in_ready, 1'b0);
        collect("hold_first", 0, 2);
        tick();
        push_exp(100, 3);
        in_valid = 1'b0;
        collect("hold_second", 0, 1);

        // Reset on the 4th RUN cycle aborts the operation.
        send(300, 20);
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_quot", quot, 0);
        chk("abort_dz", div_zero, 1'b0);
`ifdef PIPE_DIV_REM_EN
        chk("abort_rem", rem, 0);
`endif
        send(300, 20);  in_valid = 1'b0; collect("after_abort", 0, 1);

        for (int k = 0; k < 8; k++) begin
            a = W'($urandom_range(0, 1023));
            b = (k == 3) ? '0 : W'($urandom_range(1, 1023));
            send(a, b);
            in_valid = 1'b0;
            collect("rand", k % 3, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
